// File: rtl/melody_sequencer.sv
// Song-ROM note sequencer feeding the buzzer's music_scale input.
// Steps through built-in jingles, holding each note for a programmed number of tempo ticks.
module melody_sequencer #(
  parameter int unsigned TICK_DIV = 12_499_999
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       play,
  input  logic [1:0] song_sel,
  input  logic       loop,
  input  logic       stop,
  output logic [5:0] music_scale,
  output logic       busy,
  output logic       done
);

  localparam logic [5:0] END_SCALE = 6'd63;

  typedef enum logic {IDLE, PLAY} state_t;

  state_t      state, state_n;
  logic [23:0] tick_cnt;
  logic        tick;
  logic [4:0]  addr, addr_n;
  logic [3:0]  remaining, remaining_n;
  logic        loop_q, loop_n;
  logic [5:0]  scale_n;
  logic        busy_n, done_n;

  logic [4:0]  start_addr, next_addr, base_addr;
  logic [8:0]  start_entry, next_entry, base_entry;

  // Free-running tempo divider; shares reset and divide with the buzzer so phases match.
  assign tick = (tick_cnt == 24'(TICK_DIV));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + 24'd1;
  end

  function automatic logic [8:0] song_rom(input logic [4:0] a);
    case (a)
      5'd0:    song_rom = {6'd8,  3'd0};
      5'd1:    song_rom = {6'd10, 3'd0};
      5'd2:    song_rom = {6'd12, 3'd1};
      5'd8:    song_rom = {6'd12, 3'd0};
      5'd9:    song_rom = {6'd8,  3'd0};
      5'd16:   song_rom = {6'd12, 3'd1};
      5'd17:   song_rom = {6'd11, 3'd1};
      5'd18:   song_rom = {6'd10, 3'd1};
      5'd19:   song_rom = {6'd8,  3'd3};
      5'd24:   song_rom = {6'd15, 3'd0};
      5'd25:   song_rom = {6'd0,  3'd0};
      5'd26:   song_rom = {6'd15, 3'd0};
      default: song_rom = {END_SCALE, 3'd0};
    endcase
  endfunction

  assign start_addr  = {song_sel, 3'd0};
  assign next_addr   = {addr[4:3], addr[2:0] + 3'd1};
  assign base_addr   = {addr[4:3], 3'd0};
  assign start_entry = song_rom(start_addr);
  assign next_entry  = song_rom(next_addr);
  assign base_entry  = song_rom(base_addr);

  always_comb begin
    state_n     = state;
    addr_n      = addr;
    remaining_n = remaining;
    loop_n      = loop_q;
    scale_n     = music_scale;
    done_n      = 1'b0;

    if (stop) begin
      state_n = IDLE;
      scale_n = '0;
    end else if (play) begin
      // Play wins over a coincident tick: the fresh first note is not decremented.
      loop_n = loop;
      addr_n = start_addr;
      if (start_entry[8:3] == END_SCALE) begin
        state_n     = IDLE;
        scale_n     = '0;
        remaining_n = '0;
        done_n      = 1'b1;
      end else begin
        state_n     = PLAY;
        scale_n     = start_entry[8:3];
        remaining_n = {1'b0, start_entry[2:0]} + 4'd1;
      end
    end else if (state == PLAY && tick) begin
      if (remaining > 4'd1) begin
        remaining_n = remaining - 4'd1;
      end else if (next_entry[8:3] != END_SCALE) begin
        addr_n      = next_addr;
        scale_n     = next_entry[8:3];
        remaining_n = {1'b0, next_entry[2:0]} + 4'd1;
      end else if (loop_q) begin
        addr_n      = base_addr;
        scale_n     = base_entry[8:3];
        remaining_n = {1'b0, base_entry[2:0]} + 4'd1;
      end else begin
        addr_n      = next_addr;
        state_n     = IDLE;
        scale_n     = '0;
        remaining_n = '0;
        done_n      = 1'b1;
      end
    end

    busy_n = (state_n == PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      remaining   <= '0;
      loop_q      <= 1'b0;
      music_scale <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      addr        <= addr_n;
      remaining   <= remaining_n;
      loop_q      <= loop_n;
      music_scale <= scale_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

endmodule
